// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch and data ports.
// Data wins contention unless fetch has lost STARVE_MAX arbitrations in a row.
module mem_port_arbiter #(
    parameter int unsigned AW         = 64,
    parameter int unsigned DW         = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_valid,
    output logic [31:0]   o_if_rdata,
    input  logic          i_ds_req,
    input  logic          i_ds_rw,
    input  logic [AW-1:0] i_ds_addr,
    input  logic [DW-1:0] i_ds_wdata,
    output logic          o_ds_gnt,
    output logic          o_ds_valid,
    output logic [DW-1:0] o_ds_rdata,
    output logic          o_mem_cs,
    output logic          o_mem_rw,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_ready,
    output logic          o_busy
);

    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DS_ACC = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved  = (starve_cnt == CW'(STARVE_MAX));
    assign o_mem_cs = (state != IDLE);
    assign o_busy   = (state != IDLE);

    // Grants depend only on state, requests and the starvation counter; gated off during reset.
    always_comb begin
        o_if_gnt = 1'b0;
        o_ds_gnt = 1'b0;
        if (i_rst && (state == IDLE)) begin
            if (i_ds_req && !(i_if_req && starved)) begin
                o_ds_gnt = 1'b1;
            end else if (i_if_req) begin
                o_if_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            o_if_valid  <= 1'b0;
            o_if_rdata  <= '0;
            o_ds_valid  <= 1'b0;
            o_ds_rdata  <= '0;
            o_mem_rw    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_if_valid <= 1'b0;
            o_ds_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (o_ds_gnt) begin
                        o_mem_addr  <= i_ds_addr;
                        o_mem_rw    <= i_ds_rw;
                        o_mem_wdata <= i_ds_wdata;
                        state       <= DS_ACC;
                        if (i_if_req && !starved) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                    end else if (o_if_gnt) begin
                        o_mem_addr  <= i_if_addr;
                        o_mem_rw    <= 1'b0;
                        o_mem_wdata <= '0;
                        starve_cnt  <= '0;
                        state       <= IF_ACC;
                    end
                end
                IF_ACC: begin
                    if (i_mem_ready) begin
                        // Select the 32-bit instruction word within the 64-bit memory beat.
                        o_if_rdata <= o_mem_addr[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
                        o_if_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                DS_ACC: begin
                    if (i_mem_ready) begin
                        if (!o_mem_rw) begin
                            o_ds_rdata <= i_mem_rdata;
                        end
                        o_ds_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table plus contention and reset sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt, if_valid;
    logic [31:0] if_rdata;
    logic        ds_req = 1'b0, ds_rw = 1'b0;
    logic [63:0] ds_addr = '0, ds_wdata = '0;
    logic        ds_gnt, ds_valid;
    logic [63:0] ds_rdata;
    logic        mem_cs, mem_rw, busy;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(64), .DW(64), .STARVE_MAX(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_valid(if_valid), .o_if_rdata(if_rdata),
        .i_ds_req(ds_req), .i_ds_rw(ds_rw), .i_ds_addr(ds_addr), .i_ds_wdata(ds_wdata),
        .o_ds_gnt(ds_gnt), .o_ds_valid(ds_valid), .o_ds_rdata(ds_rdata),
        .o_mem_cs(mem_cs), .o_mem_rw(mem_rw), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready), .o_busy(busy)
    );

    typedef struct {
        logic        ifr;
        logic [63:0] ifa;
        logic        dsr;
        logic        dsrw;
        logic [63:0] dsa;
        logic [63:0] dsw;
        logic        rdy;
        logic [63:0] rd;
        logic        igt, dgt, iv, dv, cs, rw;
        logic [63:0] ma, mw;
        logic        bsy;
        logic [31:0] ird;
        logic [63:0] drd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic ifr, input logic [63:0] ifa, input logic dsr, input logic dsrw,
                        input logic [63:0] dsa, input logic [63:0] dsw, input logic rdy,
                        input logic [63:0] rd, input logic igt, input logic dgt, input logic iv,
                        input logic dv, input logic cs, input logic rw, input logic [63:0] ma,
                        input logic [63:0] mw, input logic bsy, input logic [31:0] ird,
                        input logic [63:0] drd);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.dsr = dsr; v.dsrw = dsrw; v.dsa = dsa; v.dsw = dsw;
        v.rdy = rdy; v.rd = rd; v.igt = igt; v.dgt = dgt; v.iv = iv; v.dv = dv;
        v.cs = cs; v.rw = rw; v.ma = ma; v.mw = mw; v.bsy = bsy; v.ird = ird; v.drd = drd;
        vecs.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".if_gnt"}, 64'(if_gnt), 64'd0);
        chk({tag, ".ds_gnt"}, 64'(ds_gnt), 64'd0);
        chk({tag, ".if_valid"}, 64'(if_valid), 64'd0);
        chk({tag, ".ds_valid"}, 64'(ds_valid), 64'd0);
        chk({tag, ".if_rdata"}, 64'(if_rdata), 64'd0);
        chk({tag, ".ds_rdata"}, ds_rdata, 64'd0);
        chk({tag, ".cs"}, 64'(mem_cs), 64'd0);
        chk({tag, ".rw"}, 64'(mem_rw), 64'd0);
        chk({tag, ".addr"}, mem_addr, 64'd0);
        chk({tag, ".wdata"}, mem_wdata, 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    localparam logic [63:0] MA = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] MW = 64'h1122_3344_5566_7788;
    localparam logic [63:0] MR = 64'h0123_4567_89AB_CDEF;
    localparam logic [31:0] HI = 32'hAAAA_BBBB;
    localparam logic [31:0] LO = 32'hCCCC_DDDD;

    initial begin
        logic got_if [$];
        logic exp_if [10];
        int   cyc;
        // Fetch with two-cycle memory wait, upper word.
        addv(1,'h104,0,0,0,0,0,0,     1,0,0,0,0,0,0,0,0,0,0);
        addv(0,0,0,0,0,0,0,0,         0,0,0,0,1,0,'h104,0,1,0,0);
        addv(0,0,0,0,0,0,1,MA,        0,0,0,0,1,0,'h104,0,1,0,0);
        addv(0,0,0,0,0,0,0,0,         0,0,1,0,0,0,'h104,0,0,HI,0);
        addv(0,0,0,0,0,0,0,0,         0,0,0,0,0,0,'h104,0,0,HI,0);
        // Data write, then a read accepted on the write's valid cycle.
        addv(0,0,1,1,'h20,MW,0,0,     0,1,0,0,0,0,'h104,0,0,HI,0);
        addv(0,0,0,0,0,0,1,MA,        0,0,0,0,1,1,'h20,MW,1,HI,0);
        addv(0,0,1,0,'h28,0,0,0,      0,1,0,1,0,1,'h20,MW,0,HI,0);
        addv(0,0,0,0,0,0,1,MR,        0,0,0,0,1,0,'h28,0,1,HI,0);
        addv(0,0,0,0,0,0,0,0,         0,0,0,1,0,0,'h28,0,0,HI,MR);
        // Three back-to-back reads with ds_req held.
        addv(0,0,1,0,'h40,0,0,0,      0,1,0,0,0,0,'h28,0,0,HI,MR);
        addv(0,0,1,0,'h40,0,1,'h1111, 0,0,0,0,1,0,'h40,0,1,HI,MR);
        addv(0,0,1,0,'h48,0,0,0,      0,1,0,1,0,0,'h40,0,0,HI,'h1111);
        addv(0,0,1,0,'h48,0,1,'h2222, 0,0,0,0,1,0,'h48,0,1,HI,'h1111);
        addv(0,0,1,0,'h50,0,0,0,      0,1,0,1,0,0,'h48,0,0,HI,'h2222);
        addv(0,0,0,0,0,0,1,'h3333,    0,0,0,0,1,0,'h50,0,1,HI,'h2222);
        addv(0,0,0,0,0,0,0,0,         0,0,0,1,0,0,'h50,0,0,HI,'h3333);
        // Fetch of the lower word.
        addv(1,'h108,0,0,0,0,0,0,     1,0,0,0,0,0,'h50,0,0,HI,'h3333);
        addv(0,0,0,0,0,0,1,MA,        0,0,0,0,1,0,'h108,0,1,HI,'h3333);
        addv(0,0,0,0,0,0,0,0,         0,0,1,0,0,0,'h108,0,0,LO,'h3333);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        foreach (vecs[i]) begin
            string t;
            @(posedge clk);
            #1;
            if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
            ds_req = vecs[i].dsr; ds_rw = vecs[i].dsrw;
            ds_addr = vecs[i].dsa; ds_wdata = vecs[i].dsw;
            mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rd;
            @(negedge clk);
            t = $sformatf("v%0d", i);
            chk({t, ".if_gnt"}, 64'(if_gnt), 64'(vecs[i].igt));
            chk({t, ".ds_gnt"}, 64'(ds_gnt), 64'(vecs[i].dgt));
            chk({t, ".if_valid"}, 64'(if_valid), 64'(vecs[i].iv));
            chk({t, ".ds_valid"}, 64'(ds_valid), 64'(vecs[i].dv));
            chk({t, ".cs"}, 64'(mem_cs), 64'(vecs[i].cs));
            chk({t, ".busy"}, 64'(busy), 64'(vecs[i].bsy));
            chk({t, ".rw"}, 64'(mem_rw), 64'(vecs[i].rw));
            chk({t, ".addr"}, mem_addr, vecs[i].ma);
            chk({t, ".wdata"}, mem_wdata, vecs[i].mw);
            chk({t, ".if_rdata"}, 64'(if_rdata), 64'(vecs[i].ird));
            chk({t, ".ds_rdata"}, ds_rdata, vecs[i].drd);
        end

        // Contention: both ports requesting, memory always ready.
        exp_if = '{0,0,0,0,1,0,0,0,0,1};
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 64'h200;
        ds_req = 1'b1; ds_rw = 1'b0; ds_addr = 64'h300; ds_wdata = '0;
        mem_ready = 1'b1; mem_rdata = '0;
        cyc = 0;
        while (got_if.size() < 10 && cyc < 60) begin
            @(negedge clk);
            if (if_gnt && ds_gnt) chk("contend.both_gnt", 64'd1, 64'd0);
            if (if_gnt || ds_gnt) got_if.push_back(if_gnt);
            cyc++;
        end
        if (got_if.size() < 10) chk("contend.timeout", 64'(got_if.size()), 64'd10);
        foreach (got_if[i]) chk($sformatf("contend.grant%0d_is_fetch", i), 64'(got_if[i]), 64'(exp_if[i]));

        // Drain, then abandon a data read with reset mid-access.
        @(posedge clk);
        #1;
        if_req = 1'b0; ds_req = 1'b0;
        cyc = 0;
        while (busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain.busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        ds_req = 1'b1; ds_rw = 1'b0; ds_addr = 64'h60;
        @(negedge clk);
        chk("rst.ds_gnt", 64'(ds_gnt), 64'd1);
        @(posedge clk);
        #1;
        ds_req = 1'b0;
        @(negedge clk);
        chk("rst.cs_before", 64'(mem_cs), 64'd1);
        if_req = 1'b1; ds_req = 1'b1;
        rst = 1'b0;
        #1;
        check_all_zero("rst.during");
        @(posedge clk);
        #1;
        check_all_zero("rst.held");
        if_req = 1'b0; ds_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1; mem_rdata = MR;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst.after%0d.ds_valid", k), 64'(ds_valid), 64'd0);
            chk($sformatf("rst.after%0d.cs", k), 64'(mem_cs), 64'd0);
            chk($sformatf("rst.after%0d.busy", k), 64'(busy), 64'd0);
            chk($sformatf("rst.after%0d.ds_rdata", k), ds_rdata, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch port and data-access port.
- Uses a req/gnt acceptance handshake and a valid completion pulse on each side, with a ready-based handshake on the memory side.
- Data accesses have priority, limited by a starvation guard so fetch is still served.
- Sits between the pipeline's PM/DM interfaces and the shared memory macro.

Parameters:
- AW, 64, address width on all ports.
- DW, 64, memory and data-port data width.
- STARVE_MAX, 4, number of consecutive lost arbitrations after which fetch wins over data.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_if_req  in  1  fetch request, held until granted
- i_if_addr  in  AW  fetch byte address
- o_if_gnt  out  1  fetch request accepted this cycle (combinational)
- o_if_valid  out  1  one-cycle pulse, fetch data valid
- o_if_rdata  out  32  fetched instruction word
- i_ds_req  in  1  data request, held until granted
- i_ds_rw  in  1  1 = write, 0 = read
- i_ds_addr  in  AW  data byte address
- i_ds_wdata  in  DW  write data
- o_ds_gnt  out  1  data request accepted this cycle (combinational)
- o_ds_valid  out  1  one-cycle pulse, data access complete
- o_ds_rdata  out  DW  read data
- o_mem_cs  out  1  memory access active
- o_mem_rw  out  1  1 = write
- o_mem_addr  out  AW  memory address
- o_mem_wdata  out  DW  memory write data
- i_mem_rdata  in  DW  memory read data, valid when i_mem_ready=1
- i_mem_ready  in  1  memory completes the current access this cycle
- o_busy  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, IF_ACC, DS_ACC.
- Grants: o_*_gnt is asserted only in IDLE, and is a function of state, requests and the starvation counter only (no path from memory inputs).
- Arbitration in IDLE:
  - Only ds_req: grant data.
  - Only if_req: grant fetch.
  - Both requesting: grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
  - At most one gnt per cycle.
- On the accepting edge: latch address, rw and wdata (rw is 0 for fetch), then enter IF_ACC or DS_ACC.
- In IF_ACC/DS_ACC:
  - o_mem_cs=1 and o_mem_addr/rw/wdata come from the latches, stable for the whole access.
  - Requests are ignored.
  - Remain in the state until i_mem_ready=1 is sampled.
- On the ready edge:
  - Capture read data and go to IDLE.
  - Next cycle, pulse the matching o_*_valid for exactly 1 cycle.
  - Fetch: o_if_rdata = addr[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0].
  - Data read: o_ds_rdata = i_mem_rdata.
  - Write: o_ds_valid pulses and o_ds_rdata holds its previous value.
- Latency and throughput:
  - Accept at cycle N, ready at N+k (k≥1), valid at N+k+1.
  - A new request may be accepted in the same cycle valid is high, so back-to-back throughput is one access per 2 cycles minimum.
- o_mem_cs=0 in IDLE; the other mem outputs are don't-care while cs=0 but hold their latched values.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - +1 each cycle if_req is high and data is granted, saturating at STARVE_MAX.
  - Cleared on fetch grant.
  - Unchanged otherwise.
- Reset (i_rst=0, any time, including mid-access):
  - Immediately returns to IDLE.
  - All outputs 0: gnt, valid, rdata, cs, rw, addr, wdata, busy.
  - starve_cnt=0.
  - An in-flight access is abandoned with no valid pulse, even if i_mem_ready arrives later.
- o_busy = (state != IDLE).
- A request that drops before grant is legal and is simply not served.

Test Plan:
- Single fetch: if_req, addr=0x104, memory ready 2 cycles after cs, rdata=0xAAAA_BBBB_CCCC_DDDD -> gnt at N, cs high N+1..N+2, o_if_valid at N+3, o_if_rdata=0xAAAA_BBBB.
- Data write/read: write addr=0x20 wdata=0x1122334455667788 -> mem rw=1 with those values, ds_valid pulses; then read with ready at first ACC cycle -> ds_valid 2 cycles after gnt, rdata equals the memory value.
- Contention with STARVE_MAX=4: if_req and ds_req held high, memory ready immediately -> data granted 4 times, then the 5th grant goes to fetch, and the counter is 0 after it.
- Back-to-back: ds_req held for 3 accesses -> grants every 2 cycles, with each new grant coinciding with the prior valid.
- Reset mid-access: assert i_rst=0 in DS_ACC before ready, release, then drive i_mem_ready=1 -> no ds_valid, cs=0, state IDLE, all outputs 0 during reset.
